apb_master_bridge: RTL

//  APB requester: turns single-beat commands from a local valid/ready port into
//  APB IDLE/SETUP/ACCESS transfers toward the APB slave.

---
 rtl/apb_master_bridge.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/apb_master_bridge.sv
// APB requester bridge: single-beat valid/ready commands in, APB SETUP/ACCESS transfers out,
// with a registered one-cycle response strobe and a bounded wait-state timeout.
module apb_master_bridge #(
  parameter int A_WIDTH = 8,
  parameter int D_WIDTH = 8,
  parameter int TIMEOUT = 16
) (
  input  logic               p_clk,
  input  logic               p_rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [A_WIDTH-1:0] cmd_addr,
  input  logic [D_WIDTH-1:0] cmd_wdata,
  output logic               rsp_valid,
  output logic [D_WIDTH-1:0] rsp_rdata,
  output logic               rsp_err,
  output logic               rsp_timeout,
  output logic               p_sel,
  output logic               p_enable,
  output logic               p_write,
  output logic [A_WIDTH-1:0] p_addr,
  output logic [D_WIDTH-1:0] wr_data,
  input  logic [D_WIDTH-1:0] rd_data,
  input  logic               p_ready,
  input  logic               p_slverr
);

  // A zero TIMEOUT still needs a legal one-bit counter; it simply never expires.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t        state_r;
  logic [CW-1:0] wait_cnt_r;

  logic timeout_s;
  logic done_s;
  logic cmd_ready_s;
  logic accept_s;

  // Completion decode and command handshake; cmd_ready follows p_ready in ACCESS.
  always_comb begin
    timeout_s   = 1'b0;
    done_s      = 1'b0;
    cmd_ready_s = 1'b0;
    if ((TIMEOUT != 0) && (state_r == ACCESS) && !p_ready && (wait_cnt_r == CNT_LAST)) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
    if (state_r == ACCESS) begin
      done_s = p_ready || timeout_s;
    end else begin
      done_s = 1'b0;
    end
    case (state_r)
      IDLE:    cmd_ready_s = !p_rst;
      ACCESS:  cmd_ready_s = done_s && !p_rst;
      default: cmd_ready_s = 1'b0;
    endcase
    accept_s = cmd_valid && cmd_ready_s;
  end

  assign cmd_ready = cmd_ready_s;

  // Transfer FSM with registered APB and response outputs.
  always_ff @(posedge p_clk or posedge p_rst) begin
    if (p_rst) begin
      state_r     <= IDLE;
      wait_cnt_r  <= CNT_ZERO;
      p_sel       <= 1'b0;
      p_enable    <= 1'b0;
      p_write     <= 1'b0;
      p_addr      <= {A_WIDTH{1'b0}};
      wr_data     <= {D_WIDTH{1'b0}};
      rsp_valid   <= 1'b0;
      rsp_rdata   <= {D_WIDTH{1'b0}};
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          p_enable <= 1'b0;
          if (accept_s) begin
            state_r <= SETUP;
            p_sel   <= 1'b1;
            p_write <= cmd_write;
            p_addr  <= cmd_addr;
            wr_data <= cmd_wdata;
          end else begin
            p_sel <= 1'b0;
          end
        end
        SETUP: begin
          state_r    <= ACCESS;
          p_sel      <= 1'b1;
          p_enable   <= 1'b1;
          wait_cnt_r <= CNT_ZERO;
        end
        ACCESS: begin
          if (done_s) begin
            rsp_valid   <= 1'b1;
            rsp_timeout <= timeout_s;
            rsp_err     <= timeout_s ? 1'b1 : p_slverr;
            rsp_rdata   <= (timeout_s || p_write) ? {D_WIDTH{1'b0}} : rd_data;
            p_enable    <= 1'b0;
            // Back-to-back: skip IDLE and go straight into SETUP of the next command.
            if (accept_s) begin
              state_r <= SETUP;
              p_sel   <= 1'b1;
              p_write <= cmd_write;
              p_addr  <= cmd_addr;
              wr_data <= cmd_wdata;
            end else begin
              state_r <= IDLE;
              p_sel   <= 1'b0;
            end
          end else if (wait_cnt_r != CNT_MAX) begin
            wait_cnt_r <= wait_cnt_r + CNT_ONE;
          end else begin
            wait_cnt_r <= wait_cnt_r;
          end
        end
        default: begin
          state_r  <= IDLE;
          p_sel    <= 1'b0;
          p_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule
